// File: rtl/wb_sensor_if.sv
// Wishbone slave bus bundle for the wb_sensor peripheral.
interface wb_sensor_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_sensor.sv
// Wishbone sensor peripheral: synchronise, debounce, edge-qualify, latch events, raise IRQ.
// Optional SENSOR_TIMESTAMP_EN builds a first-event cycle timestamp readable at 0x14.
module wb_sensor #(
    parameter int unsigned NUM_SENSORS     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    wb_sensor_if.slave             wb,
    input  logic [NUM_SENSORS-1:0] sensor_in,
    output logic                   intr,
    output logic                   alarm_out
);
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SENSORS-1:0]           sync1_q, sync2_q;
    logic [NUM_SENSORS-1:0]           level_q, level_d, level_prev_q;
    logic [NUM_SENSORS-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [NUM_SENSORS-1:0]           pending_q, pending_d, mask_q, edge_q;
    logic [NUM_SENSORS-1:0]           event_set, w1c;
    logic                             alarm_q, alarm_out_q, intr_q, ack_q;
    logic [31:0]                      dat_q, rdata, ts_value;
    logic [2:0]                       reg_sel;
    logic                             access, wr;

    assign reg_sel = wb.wb_adr_i[4:2];
    assign access  = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
    assign wr      = access & wb.wb_we_i & wb.wb_sel_i[0];

    // A level change fires an event when the new level matches the selected edge polarity.
    assign event_set = (level_q ^ level_prev_q) & ~(level_q ^ edge_q);
    assign w1c       = (wr && reg_sel == 3'd1) ? wb.wb_dat_i[NUM_SENSORS-1:0] : '0;
    // Hardware set takes priority over a same-cycle W1C clear.
    assign pending_d = (pending_q & ~w1c) | event_set;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            3'd0:    rdata[NUM_SENSORS-1:0] = level_q;
            3'd1:    rdata[NUM_SENSORS-1:0] = pending_q;
            3'd2:    rdata[NUM_SENSORS-1:0] = mask_q;
            3'd3:    rdata[NUM_SENSORS-1:0] = edge_q;
            3'd4:    rdata[0] = alarm_q;
            3'd5:    rdata = ts_value;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            cnt_q        <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            edge_q       <= '0;
            alarm_q      <= 1'b0;
            alarm_out_q  <= 1'b0;
            intr_q       <= 1'b0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
        end else begin
            sync1_q      <= sensor_in;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            if (wr && reg_sel == 3'd2) mask_q  <= wb.wb_dat_i[NUM_SENSORS-1:0];
            if (wr && reg_sel == 3'd3) edge_q  <= wb.wb_dat_i[NUM_SENSORS-1:0];
            if (wr && reg_sel == 3'd4) alarm_q <= wb.wb_dat_i[0];
            intr_q       <= |(pending_q & mask_q);
            alarm_out_q  <= alarm_q;
            ack_q        <= access;
            dat_q        <= (access && !wb.wb_we_i) ? rdata : '0;
        end
    end

`ifdef SENSOR_TIMESTAMP_EN
    logic [31:0] cycle_q, ts_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
            ts_q    <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (pending_q == '0 && pending_d != '0) ts_q <= cycle_q;
        end
    end

    assign ts_value = ts_q;
`else
    assign ts_value = '0;
`endif

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign intr        = intr_q;
    assign alarm_out   = alarm_out_q;

    logic unused_bits;
    assign unused_bits = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_sel_i[3:1],
                           wb.wb_dat_i[31:NUM_SENSORS]};
endmodule

// File: tb/tb_wb_sensor.sv
// Self-checking bench for wb_sensor (NUM_SENSORS=4, DEBOUNCE_CYCLES=4).
module tb_wb_sensor;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sensor_in;
    logic       intr, alarm_out;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        string       name;
        logic [4:0]  adr;
        logic        wr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[11];

    wb_sensor_if bus();

    wb_sensor #(.NUM_SENSORS(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb        (bus),
        .sensor_in (sensor_in),
        .intr      (intr),
        .alarm_out (alarm_out)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'h0;
        bus.wb_adr_i = 32'h0;
        bus.wb_dat_i = 32'h0;
    endtask

    task automatic bus_cycle(input logic [4:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rd);
        int n = 0;
        bus.wb_adr_i = {27'h0, adr};
        bus.wb_we_i  = we;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.wb_ack_o && n < 16);
        total++;
        if (!bus.wb_ack_o) begin
            bad++;
            $display("FAIL ack timeout: got no ack want ack within 16 cycles");
        end
        rd = bus.wb_dat_o;
        bus_idle();
        tick(1);
        check("ack single cycle", {31'h0, bus.wb_ack_o}, 32'h0);
        check("dat_o idle zero", bus.wb_dat_o, 32'h0);
    endtask

    task automatic wb_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        bus_cycle(adr, 1'b1, dat, sel, rd);
    endtask

    task automatic wb_read(input logic [4:0] adr, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        exp_t e;
        sb_q.push_back('{name: name, exp: exp});
        bus_cycle(adr, 1'b0, 32'h0, 4'h0, rd);
        e = sb_q.pop_front();
        check(e.name, rd, e.exp);
    endtask

    initial begin
        logic [31:0] ts1, ts2;
        logic [3:0]  ackpat;

        vecs[0]  = '{"mask rw lane0",    5'h08, 1'b1, 32'h000000A5, 4'h1, 32'h5};
        vecs[1]  = '{"mask lane0 off",   5'h08, 1'b1, 32'h000000FF, 4'hE, 32'h5};
        vecs[2]  = '{"edge rw",          5'h0C, 1'b1, 32'h00000003, 4'hF, 32'h3};
        vecs[3]  = '{"status ro",        5'h00, 1'b1, 32'h0000000F, 4'h1, 32'h0};
        vecs[4]  = '{"alarm bit0",       5'h10, 1'b1, 32'h00000003, 4'h1, 32'h1};
        vecs[5]  = '{"alarm clear",      5'h10, 1'b1, 32'h00000002, 4'h1, 32'h0};
        vecs[6]  = '{"gap 0x18",         5'h18, 1'b1, 32'h000000FF, 4'h1, 32'h0};
        vecs[7]  = '{"gap 0x1c",         5'h1C, 1'b1, 32'h000000FF, 4'h1, 32'h0};
        vecs[8]  = '{"timestamp ro",     5'h14, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[9]  = '{"edge clear",       5'h0C, 1'b1, 32'h00000000, 4'h1, 32'h0};
        vecs[10] = '{"mask clear",       5'h08, 1'b1, 32'h00000000, 4'h1, 32'h0};

        reset     = 1'b0;
        sensor_in = 4'h0;
        bus_idle();
        tick(3);
        check("reset intr", {31'h0, intr}, 32'h0);
        check("reset alarm_out", {31'h0, alarm_out}, 32'h0);
        check("reset ack", {31'h0, bus.wb_ack_o}, 32'h0);
        reset = 1'b1;
        tick(2);

        foreach (vecs[i]) begin
            if (vecs[i].wr) wb_write(vecs[i].adr, vecs[i].wdat, vecs[i].sel);
            wb_read(vecs[i].adr, vecs[i].exp, vecs[i].name);
        end

        // Back-to-back strobe: ack on alternate cycles.
        bus.wb_adr_i = 32'h08;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            tick(1);
            ackpat[k] = bus.wb_ack_o;
        end
        bus_idle();
        check("back-to-back ack", {28'h0, ackpat}, 32'hA);
        tick(2);

        // Short glitch is rejected.
        wb_write(5'h0C, 32'hF, 4'h1);
        wb_write(5'h08, 32'hF, 4'h1);
        sensor_in[0] = 1'b1;
        tick(3);
        sensor_in[0] = 1'b0;
        tick(10);
        wb_read(5'h00, 32'h0, "glitch status");
        wb_read(5'h04, 32'h0, "glitch pending");
        check("glitch intr", {31'h0, intr}, 32'h0);

        // Held rising edge: pending at +7 cycles, intr at +8.
        wb_write(5'h08, 32'h2, 4'h1);
        sensor_in[1] = 1'b1;
        tick(6);
        check("pending before latency", {28'h0, dut.pending_q}, 32'h0);
        tick(1);
        check("pending at latency", {28'h0, dut.pending_q}, 32'h2);
        check("intr lags pending", {31'h0, intr}, 32'h0);
        tick(1);
        check("intr asserted", {31'h0, intr}, 32'h1);
        wb_read(5'h00, 32'h2, "held status");
        sensor_in[1] = 1'b0;
        wb_write(5'h04, 32'h2, 4'h1);
        check("intr after w1c", {31'h0, intr}, 32'h0);
        tick(10);
        wb_read(5'h04, 32'h0, "rising-only ignores fall");

        // Falling-edge qualification.
        wb_write(5'h0C, 32'h0, 4'h1);
        sensor_in[2] = 1'b1;
        tick(10);
        wb_read(5'h04, 32'h0, "fall mode ignores rise");
        sensor_in[2] = 1'b0;
        tick(10);
        wb_read(5'h04, 32'h4, "fall mode pending");
        wb_write(5'h04, 32'h4, 4'h1);
        wb_read(5'h04, 32'h0, "fall pending cleared");

        // Event set and W1C commit on the same edge: set wins.
        wb_write(5'h0C, 32'hF, 4'h1);
        sensor_in[3] = 1'b1;
        tick(6);
        wb_write(5'h04, 32'h8, 4'h1);
        wb_read(5'h04, 32'h8, "set beats w1c");
        wb_write(5'h04, 32'h8, 4'h1);
        wb_read(5'h04, 32'h0, "w1c after collision");
        sensor_in[3] = 1'b0;
        tick(10);

        // Alarm output follows ALARM one cycle after the ack.
        bus.wb_adr_i = 32'h10;
        bus.wb_dat_i = 32'h1;
        bus.wb_sel_i = 4'h1;
        bus.wb_we_i  = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        tick(1);
        check("alarm write ack", {31'h0, bus.wb_ack_o}, 32'h1);
        check("alarm_out in ack cycle", {31'h0, alarm_out}, 32'h0);
        bus_idle();
        tick(1);
        check("alarm_out after ack", {31'h0, alarm_out}, 32'h1);
        wb_read(5'h10, 32'h1, "alarm readback");

        // Timestamp capture on the first event only.
        sensor_in[0] = 1'b1;
        tick(10);
        bus_cycle(5'h14, 1'b0, 32'h0, 4'h0, ts1);
        sensor_in[1] = 1'b1;
        tick(10);
        bus_cycle(5'h14, 1'b0, 32'h0, 4'h0, ts2);
`ifdef SENSOR_TIMESTAMP_EN
        check("timestamp nonzero", {31'h0, (ts1 != 32'h0)}, 32'h1);
        check("timestamp held", ts2, ts1);
`else
        check("timestamp absent first", ts1, 32'h0);
        check("timestamp absent second", ts2, 32'h0);
`endif
        wb_read(5'h04, 32'h3, "two events pending");

        // Asynchronous reset mid-transfer with ALARM=1 and PENDING=0x3.
        wb_write(5'h08, 32'h3, 4'h1);
        tick(1);
        check("intr before reset", {31'h0, intr}, 32'h1);
        bus.wb_adr_i = 32'h04;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        tick(1);
        check("ack before reset", {31'h0, bus.wb_ack_o}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async reset ack", {31'h0, bus.wb_ack_o}, 32'h0);
        check("async reset dat_o", bus.wb_dat_o, 32'h0);
        check("async reset intr", {31'h0, intr}, 32'h0);
        check("async reset alarm_out", {31'h0, alarm_out}, 32'h0);
        bus_idle();
        sensor_in = 4'h0;
        tick(2);
        reset = 1'b1;
        tick(1);
        for (int a = 0; a < 8; a++) begin
            wb_read(5'(a * 4), 32'h0, $sformatf("post-reset reg 0x%02h", a * 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_sensor.md
Name: wb_sensor

Overview:
- Wishbone slave peripheral for the alarm/sensor-network SoC. Conditions raw motion and interruption sensor pins, latches qualified edges as pending events and raises an LM32 interrupt.
- Drives the alarm output pin under CPU control.
- Sits on the shared Wishbone interconnect beside gpio0/lcd0/ps2. It is the stage directly upstream of the CPU firmware, which consumes its events and drives the LCD.

Parameters:
- NUM_SENSORS, 4, number of sensor input channels (1..8).
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronised samples required before a level is accepted (1 ms at 50 MHz; minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wb_adr_i  in  32  Wishbone address; bits [4:2] select register.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte lanes; only lane 0 is honoured on writes.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_we_i  in  1  write enable.
- wb_ack_o  out  1  acknowledge.
- sensor_in  in  NUM_SENSORS  raw asynchronous sensor pins.
- intr  out  1  level interrupt, active-high.
- alarm_out  out  1  alarm driver.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. Asserting reset at any time, including mid-debounce or mid-transfer, clears all state immediately:
  - wb_ack_o=0, wb_dat_o=0, intr=0, alarm_out=0.
  - Synchronisers, debounced levels and counters all 0.
  - PENDING=0, MASK=0, EDGE=0, ALARM=0.
- Synchronisation: each sensor_in bit passes through a 2-flop synchroniser.
- Debounce, per channel:
  - A counter of width clog2(DEBOUNCE_CYCLES) is held at 0 while the synced value equals the debounced level.
  - While they differ, the counter increments each cycle.
  - If the synced value returns to the debounced level, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value on that edge and the counter clears.
- Edge qualification: when a debounced level changes, an event fires on the next cycle if the change matches EDGE[n]: 1 = rising, 0 = falling. The event sets PENDING[n].
- Latency: pin change to PENDING set is 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- Registers (word offset from wb_adr_i[4:2]); read bits above the field width return 0:
  - 0x00 STATUS: RO, debounced levels.
  - 0x04 PENDING: W1C; writing 1 clears that bit.
  - 0x08 MASK: RW.
  - 0x0C EDGE: RW.
  - 0x10 ALARM: RW, bit0 only; alarm_out = ALARM[0] registered.
  - 0x14 TIMESTAMP: RO; see Optional Feature.
  - 0x18, 0x1C: read 0, writes ignored.
- Register access rules:
  - Writes to RO registers are ignored.
  - Writes take effect only with wb_sel_i[0]=1.
- Interrupt: intr = OR(PENDING & MASK), registered; asserts 1 cycle after the pending or mask change.
- Simultaneous event: a hardware set and a W1C clear of the same bit in the same cycle leave the bit at 1 (set wins).
- Wishbone handshake:
  - When wb_stb_i & wb_cyc_i & !wb_ack_o, the access is performed and wb_ack_o=1 for exactly one cycle on the next edge.
  - Read data is valid in the ack cycle.
  - Writes commit on the same edge that raises ack.
  - Back-to-back strobes are acked every other cycle.
  - wb_dat_o returns 0 when not acking.

Optional Feature:
- Macro: SENSOR_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter (reset 0) runs and wraps from 0xFFFFFFFF to 0.
  - On a cycle where PENDING transitions from all-zero to non-zero, the current counter value is captured into TIMESTAMP.
  - Further events do not recapture until PENDING returns to all-zero.
  - 0x14 reads TIMESTAMP.
- Undefined: no counter is built; 0x14 reads 0.

Test Plan (NUM_SENSORS=4, DEBOUNCE_CYCLES=4):
1. Reset low mid-operation with ALARM=1 and PENDING=0x3 -> alarm_out, intr, wb_ack_o go 0 asynchronously; all register reads return 0 after release.
2. Set EDGE=0xF, MASK=0xF, then apply a 3-cycle pulse on sensor_in[0] -> STATUS=0x0, PENDING=0x0, intr stays 0.
3. Set EDGE=0xF, MASK=0x2, then hold sensor_in[1]=1 for 10 cycles -> STATUS=0x2; PENDING=0x2 seven cycles after the pin change; intr=1 one cycle later. Write 0x2 to PENDING -> intr=0.
4. Set EDGE=0x0, then drive sensor_in[2] high for 10 cycles, then low -> PENDING stays 0 after the rise; PENDING=0x4 after the fall qualifies.
5. Make a sensor_in[3] event land in the same cycle as a W1C write of 0x8 -> PENDING[3] reads 1.
6. Write ALARM=1 -> alarm_out=1 one cycle after ack; read 0x10 -> 0x1. With SENSOR_TIMESTAMP_EN defined, the first event captures a nonzero counter value at 0x14 and a second event leaves it unchanged.
